// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor for the ALU datapath (ADD/SUB/ADC/SBC).
// The operands are split into STAGES equal slices. Each stage adds one slice and
// registers the carry for the next stage, so only one slice of carry chain is
// evaluated per cycle. The final stage register doubles as the output register.
// A valid/ready handshake with full backpressure controls the pipeline.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous reset, active-high
//   in_valid   a/b/ci/sub hold an operation
//   in_ready   operation accepted this cycle (combinational from out_ready/out_valid)
//   a, b       operands
//   ci         carry-in (add) / borrow-in (sub)
//   sub        0: a+b+ci, 1: a-b-ci
//   out_valid  sum/co/ovf/zero hold a result
//   out_ready  consumer takes the result this cycle
//   sum        result
//   co         carry-out (for sub, 1 = no borrow)
//   ovf        two's-complement overflow
//   zero       sum == 0
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SW = WIDTH / STAGES;

  // The whole pipeline moves in lockstep; bubbles are only squeezed at the output.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int unsigned LO  = k * SW;     // bits already summed before this stage
    localparam int unsigned REM = WIDTH - LO; // operand bits still to process, incl. this slice

    logic [REM-1:0]   a_i;
    logic [REM-1:0]   b_i;
    logic             c_i;
    logic             v_i;
    logic [WIDTH-1:0] s_i;
    logic [SW:0]      add_c;
    logic [WIDTH-1:0] s_new;

    // Stage inputs: ports for the first stage, skew/deskew registers otherwise
    if (k == 0) begin : src
      assign a_i = a;
      assign b_i = b ^ {WIDTH{sub}};
      assign c_i = ci ^ sub;
      assign v_i = in_valid;
      assign s_i = '0;
    end else begin : src
      assign a_i = stg[k-1].mid.a_q;
      assign b_i = stg[k-1].mid.b_q;
      assign c_i = stg[k-1].mid.c_q;
      assign v_i = stg[k-1].mid.v_q;
      assign s_i = stg[k-1].mid.s_q;
    end

    // One slice of ripple-carry addition; add_c[SW] is the slice carry-out
    assign add_c = {1'b0, a_i[SW-1:0]} + {1'b0, b_i[SW-1:0]} + (SW+1)'(c_i);
    assign s_new = s_i | (WIDTH'(add_c[SW-1:0]) << LO);

    if (k < STAGES - 1) begin : mid
      logic                v_q;
      logic                c_q;
      logic [WIDTH-1:0]    s_q;
      logic [REM-SW-1:0]   a_q;
      logic [REM-SW-1:0]   b_q;

      // Intermediate stage: carry, finished low slices, untouched high slices
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          v_q <= v_i;
          c_q <= add_c[SW];
          s_q <= s_new;
          a_q <= a_i[REM-1:SW];
          b_q <= b_i[REM-1:SW];
        end
      end
    end else begin : last
      // Carry into the MSB is recovered as a^b^sum at that bit position
      logic ovf_c;
      assign ovf_c = a_i[SW-1] ^ b_i[SW-1] ^ add_c[SW-1] ^ add_c[SW];

      // Final stage is the output register
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          out_valid <= 1'b0;
          sum       <= '0;
          co        <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (advance) begin
          out_valid <= v_i;
          sum       <= s_new;
          co        <= add_c[SW];
          ovf       <= ovf_c;
          zero      <= ~|s_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (STAGES = 4, 1, 32) share the same
// stimulus; an arithmetic reference model feeds per-instance expectation queues.
module tb_pipelined_addsub;

  localparam int unsigned W = 32;
  localparam int NI = 3;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         clr;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_ready;

  logic         in_ready_o  [NI];
  logic         out_valid_o [NI];
  logic [W-1:0] sum_o       [NI];
  logic         co_o        [NI];
  logic         ovf_o       [NI];
  logic         zero_o      [NI];

  res_t q [NI][$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut4 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid_o[0]), .out_ready(out_ready),
    .sum(sum_o[0]), .co(co_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0]));

  pipelined_addsub #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid_o[1]), .out_ready(out_ready),
    .sum(sum_o[1]), .co(co_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1]));

  pipelined_addsub #(.WIDTH(W), .STAGES(32)) dut32 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid_o[2]), .out_ready(out_ready),
    .sum(sum_o[2]), .co(co_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2]));

  function automatic int lat(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Reference: plain signed/unsigned integer arithmetic
  function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic c, input logic s);
    res_t   r;
    longint sa, sb, sr, ua, ub, ur;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    ua = longint'({32'd0, aa});
    ub = longint'({32'd0, bb});
    if (s) begin
      sr = sa - sb - longint'(c);
      ur = ua - ub - longint'(c);
      r.co = (ur >= 0);
    end else begin
      sr = sa + sb + longint'(c);
      ur = ua + ub + longint'(c);
      r.co = (ur >= 64'sh1_0000_0000);
    end
    r.sum  = ur[31:0];
    r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: inputs change only just after posedge, so negedge sees the values
  // the next posedge will act on.
  always @(negedge clk) begin
    if (clr) begin
      for (int k = 0; k < NI; k++) q[k].delete();
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (out_valid_o[k] && out_ready) begin
          if (q[k].size() == 0) begin
            chk($sformatf("unexpected_result[%0d]", k), 64'(out_valid_o[k]), 64'd0);
          end else begin
            res_t e;
            e = q[k].pop_front();
            chk($sformatf("result[%0d]", k),
                64'({sum_o[k], co_o[k], ovf_o[k], zero_o[k]}), 64'(e));
          end
        end
        if (in_valid && in_ready_o[k]) q[k].push_back(model(a, b, ci, sub));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic check_drained(input string tag);
    for (int k = 0; k < NI; k++)
      chk($sformatf("%s_pending[%0d]", tag, k), 64'(q[k].size()), 64'd0);
  endtask

  // Single op into an empty pipeline: latency and literal result per instance
  task automatic single(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c,
                        input logic s, input res_t e);
    int seen [NI];
    for (int k = 0; k < NI; k++) seen[k] = -1;
    a = aa; b = bb; ci = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NI; k++) begin
        if (seen[k] < 0 && out_valid_o[k]) begin
          seen[k] = n;
          chk($sformatf("single_value[%0d]", k),
              64'({sum_o[k], co_o[k], ovf_o[k], zero_o[k]}), 64'(e));
        end
      end
      tick();
    end
    for (int k = 0; k < NI; k++)
      chk($sformatf("latency[%0d]", k), 64'(seen[k]), 64'(lat(k) - 1));
  endtask

  initial begin
    int   run    [NI];
    int   maxrun [NI];
    logic [W-1:0] held [NI];

    clr = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), 64'(out_valid_o[k]), 64'd0);
      chk($sformatf("rst_flags[%0d]", k),
          64'({sum_o[k], co_o[k], ovf_o[k], zero_o[k]}), 64'd0);
    end
    clr = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      chk($sformatf("rst_in_ready[%0d]", k), 64'(in_ready_o[k]), 64'd1);
    tick();

    // Carry ripples across every slice
    single(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '{sum: 32'd0, co: 1'b1, ovf: 1'b0, zero: 1'b1});
    // Signed overflow on add
    single(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
           '{sum: 32'h8000_0000, co: 1'b0, ovf: 1'b1, zero: 1'b0});
    // Borrow on subtract
    single(32'd5, 32'd7, 1'b0, 1'b1, '{sum: 32'hFFFF_FFFE, co: 1'b0, ovf: 1'b0, zero: 1'b0});
    // Subtract with borrow-in: 5-4-1 = 0, no borrow
    single(32'd5, 32'd4, 1'b1, 1'b1, '{sum: 32'd0, co: 1'b1, ovf: 1'b0, zero: 1'b1});
    // Signed overflow on subtract: INT_MIN - 1
    single(32'h8000_0000, 32'd1, 1'b0, 1'b1,
           '{sum: 32'h7FFF_FFFF, co: 1'b1, ovf: 1'b1, zero: 1'b0});
    check_drained("single");

    // Eight back-to-back ops: results must arrive in eight consecutive cycles
    for (int k = 0; k < NI; k++) begin run[k] = 0; maxrun[k] = 0; end
    out_ready = 1'b1;
    for (int n = 0; n < 45; n++) begin
      if (n < 8) begin
        in_valid = 1'b1; a = W'(n); b = W'(n) << 28; ci = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        run[k] = out_valid_o[k] ? run[k] + 1 : 0;
        if (run[k] > maxrun[k]) maxrun[k] = run[k];
      end
    end
    for (int k = 0; k < NI; k++)
      chk($sformatf("stream_run[%0d]", k), 64'(maxrun[k]), 64'd8);
    check_drained("stream");

    // Backpressure: consumer stalls while the producer keeps offering new data
    out_ready = 1'b0;
    for (int n = 0; n < 40; n++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("stall_out_valid[%0d]", k), 64'(out_valid_o[k]), 64'd1);
      chk($sformatf("stall_in_ready[%0d]", k), 64'(in_ready_o[k]), 64'd0);
      held[k] = sum_o[k];
    end
    repeat (3) begin
      a = $urandom; b = $urandom;
      tick();
    end
    for (int k = 0; k < NI; k++)
      chk($sformatf("stall_hold[%0d]", k), 64'(sum_o[k]), 64'(held[k]));
    idle(45);
    check_drained("stall");

    // Reset with ops in flight: outputs clear at once, nothing stale afterwards
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; a = 32'h1000 + W'(n); b = 32'd3; ci = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    clr = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("clr_out_valid[%0d]", k), 64'(out_valid_o[k]), 64'd0);
      chk($sformatf("clr_sum[%0d]", k), 64'(sum_o[k]), 64'd0);
    end
    tick();
    tick();
    clr = 1'b0;
    for (int n = 0; n < 45; n++) begin
      tick();
      for (int k = 0; k < NI; k++)
        if (out_valid_o[k]) chk($sformatf("stale_after_clr[%0d]", k), 64'd1, 64'd0);
    end
    check_drained("clr");

    // Random traffic with random backpressure and corner-heavy operands
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      case ($urandom_range(3))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(3))
        0:       b = 32'h7FFF_FFFF;
        1:       b = a;
        default: b = $urandom;
      endcase
      ci  = 1'($urandom);
      sub = 1'($urandom);
      tick();
    end
    idle(45);
    check_drained("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
